// File: rtl/mulacc_pipe_l2_cfu_pkg.sv
// Shared types for the pipelined multi-state multiply-accumulate CFU:
// response status codes and the function-ID encoding.
package mulacc_pipe_l2_cfu_pkg;

    localparam int unsigned CFU_STATUS_W = 2;
    localparam logic [CFU_STATUS_W-1:0] CFU_OK       = 2'd0;
    localparam logic [CFU_STATUS_W-1:0] CFU_ERROR_OP = 2'd1;

    typedef enum logic [2:0] {
        MAC   = 3'd0,
        MSUB  = 3'd1,
        MUL   = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } mulacc_func_t;

    localparam int unsigned MULACC_N_FUNCS = 5;

endpackage

// File: rtl/mulacc_pipe_l2_cfu_if.sv
// CFU-L2 request/response bundle. The host drives through `master`, the CFU
// sits on `slave`.
interface mulacc_pipe_l2_cfu_if #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STATE_ID_W = 2,
    parameter int unsigned FUNC_ID_W  = 10
);
    import mulacc_pipe_l2_cfu_pkg::*;

    logic                    req_valid;
    logic                    req_ready;
    logic [STATE_ID_W-1:0]   req_state;
    logic [FUNC_ID_W-1:0]    req_func;
    logic [DATA_W-1:0]       req_data0;
    logic [DATA_W-1:0]       req_data1;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [CFU_STATUS_W-1:0] resp_status;
    logic [DATA_W-1:0]       resp_data;

    modport master (
        output req_valid, req_state, req_func, req_data0, req_data1, resp_ready,
        input  req_ready, resp_valid, resp_status, resp_data
    );

    modport slave (
        input  req_valid, req_state, req_func, req_data0, req_data1, resp_ready,
        output req_ready, resp_valid, resp_status, resp_data
    );

endinterface

// File: rtl/mulacc_pipe_l2_cfu_resp_fifo.sv
// Show-ahead response FIFO with occupancy count and clock enable. Head entry
// is presented whenever valid; output reads as zero while empty.
module mulacc_pipe_l2_cfu_resp_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_en,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             valid,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign valid    = (count_q != '0);
    assign count    = count_q;
    assign do_push  = clk_en & push;
    assign do_pop   = clk_en & pop & valid;
    assign pop_data = valid ? mem[rd_ptr_q] : '0;

    // Storage array; contents need no reset because reads are gated by valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (do_push != do_pop) begin
                count_q <= do_push ? count_q + CNT_W'(1) : count_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mulacc_pipe_l2_cfu.sv
// Pipelined multi-state multiply-accumulate CFU. Requests flow through a
// fixed-depth pipeline; the last stage alone touches the accumulators, so
// back-to-back hits on one state are naturally ordered. Credits bound the
// number of outstanding requests by the response FIFO depth.
module mulacc_pipe_l2_cfu
    import mulacc_pipe_l2_cfu_pkg::*;
#(
    parameter int unsigned CFU_DATA_W     = 32,
    parameter int unsigned CFU_N_STATES   = 4,
    parameter int unsigned CFU_STATE_ID_W = (CFU_N_STATES > 1) ? $clog2(CFU_N_STATES) : 1,
    parameter int unsigned CFU_FUNC_ID_W  = 10,
    parameter int unsigned CFU_LATENCY    = 2,
    parameter int unsigned CFU_FIFO_SIZE  = 2 ** $clog2(1 + CFU_LATENCY)
) (
    input logic                 clk,
    input logic                 rst_n,
    input logic                 clk_en,
    mulacc_pipe_l2_cfu_if.slave bus
);

    localparam int unsigned CNT_W   = $clog2(CFU_FIFO_SIZE + 1);
    localparam int unsigned ENTRY_W = CFU_STATUS_W + CFU_DATA_W;

    // WRITE carries operand a in the operand slot, every other function the product.
    typedef struct packed {
        logic                      valid;
        logic                      err;
        mulacc_func_t              func;
        logic [CFU_STATE_ID_W-1:0] state;
        logic [CFU_DATA_W-1:0]     operand;
    } stage_t;

    stage_t                    in_entry, last;
    stage_t                    stage_q [CFU_LATENCY];
    logic [CFU_DATA_W-1:0]     acc_q [CFU_N_STATES];
    logic                      req_fire, push, acc_we;
    logic [CFU_DATA_W-1:0]     product, acc_old, acc_new, res_data;
    logic [CFU_STATUS_W-1:0]   res_status;
    logic [CNT_W-1:0]          fifo_count, outstanding;
    logic [ENTRY_W-1:0]        fifo_data;

    // Decode the incoming request and flag illegal function/state.
    always_comb begin
        req_fire       = clk_en & bus.req_valid & bus.req_ready;
        product        = bus.req_data0 * bus.req_data1;
        in_entry       = '0;
        in_entry.valid = req_fire;
        in_entry.err   = (bus.req_func >= CFU_FUNC_ID_W'(MULACC_N_FUNCS)) ||
                         (32'(bus.req_state) >= CFU_N_STATES);
        in_entry.state = bus.req_state;
        if (!in_entry.err) begin
            in_entry.func    = mulacc_func_t'(bus.req_func[2:0]);
            in_entry.operand = (in_entry.func == WRITE) ? bus.req_data0 : product;
        end
    end

    // Pipeline shift register; advances every enabled cycle since credits
    // guarantee the FIFO can always take the last stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(CFU_LATENCY); i++) begin
                stage_q[i] <= '0;
            end
        end else if (clk_en) begin
            stage_q[0] <= in_entry;
            for (int i = 1; i < int'(CFU_LATENCY); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign last = stage_q[CFU_LATENCY-1];

    // Final stage: accumulator read-modify-write and response formation.
    always_comb begin
        acc_old = '0;
        for (int i = 0; i < int'(CFU_N_STATES); i++) begin
            if (last.state == CFU_STATE_ID_W'(i)) begin
                acc_old = acc_q[i];
            end
        end
        acc_new    = acc_old;
        acc_we     = 1'b0;
        res_status = CFU_OK;
        res_data   = '0;
        if (last.err) begin
            res_status = CFU_ERROR_OP;
        end else begin
            unique case (last.func)
                MAC: begin
                    acc_new  = acc_old + last.operand;
                    acc_we   = 1'b1;
                    res_data = acc_new;
                end
                MSUB: begin
                    acc_new  = acc_old - last.operand;
                    acc_we   = 1'b1;
                    res_data = acc_new;
                end
                MUL:   res_data = last.operand;
                READ:  res_data = acc_old;
                WRITE: begin
                    acc_new  = last.operand;
                    acc_we   = 1'b1;
                    res_data = acc_old;
                end
                default: ;
            endcase
        end
        push = clk_en & last.valid;
    end

    // Accumulator array, written only by the final stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(CFU_N_STATES); i++) begin
                acc_q[i] <= '0;
            end
        end else if (push && acc_we) begin
            for (int i = 0; i < int'(CFU_N_STATES); i++) begin
                if (last.state == CFU_STATE_ID_W'(i)) begin
                    acc_q[i] <= acc_new;
                end
            end
        end
    end

    // Credits in use: in-flight stages plus queued responses, all registered.
    always_comb begin
        outstanding = fifo_count;
        for (int i = 0; i < int'(CFU_LATENCY); i++) begin
            outstanding = outstanding + CNT_W'(stage_q[i].valid);
        end
    end

    assign bus.req_ready = rst_n & (outstanding < CNT_W'(CFU_FIFO_SIZE));

    mulacc_pipe_l2_cfu_resp_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (CFU_FIFO_SIZE)
    ) u_resp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clk_en    (clk_en),
        .push      (push),
        .push_data ({res_status, res_data}),
        .pop       (bus.resp_ready),
        .pop_data  (fifo_data),
        .valid     (bus.resp_valid),
        .count     (fifo_count)
    );

    assign {bus.resp_status, bus.resp_data} = fifo_data;

endmodule

// File: tb/tb_mulacc_pipe_l2_cfu.sv
// Bench for mulacc_pipe_l2_cfu: directed vectors with literal expectations plus
// a queue-based behavioural model checked by a per-cycle monitor.
module tb_mulacc_pipe_l2_cfu;
    import mulacc_pipe_l2_cfu_pkg::*;

    localparam int DW  = 32;
    localparam int NS  = 3;
    localparam int SW  = 2;
    localparam int FW  = 10;
    localparam int LAT = 2;
    localparam int FS  = 4;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic clk_en = 1'b1;

    mulacc_pipe_l2_cfu_if #(.DATA_W(DW), .STATE_ID_W(SW), .FUNC_ID_W(FW)) bus ();

    mulacc_pipe_l2_cfu #(
        .CFU_DATA_W     (DW),
        .CFU_N_STATES   (NS),
        .CFU_STATE_ID_W (SW),
        .CFU_FUNC_ID_W  (FW),
        .CFU_LATENCY    (LAT),
        .CFU_FIFO_SIZE  (FS)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .clk_en (clk_en),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int stalls = 0;
    int first_resp_cyc = -1;
    int last_acc_edge = 0;
    int grp_acc0 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural model: accumulators and the ordered list of expected responses.
    logic [DW-1:0] macc [NS];
    logic [DW-1:0] exp_d[$];
    logic [1:0]    exp_s[$];
    logic [DW-1:0] obs_d[$];
    logic [1:0]    obs_s[$];

    task automatic model_req(input int s, input int f, input logic [DW-1:0] a,
                             input logic [DW-1:0] b);
        logic [DW-1:0] p;
        logic [DW-1:0] r;
        logic [1:0]    st;
        p  = a * b;
        r  = '0;
        st = CFU_OK;
        if (f > 4 || s >= NS) begin
            st = CFU_ERROR_OP;
        end else begin
            case (f)
                0: begin macc[s] = macc[s] + p; r = macc[s]; end
                1: begin macc[s] = macc[s] - p; r = macc[s]; end
                2: r = p;
                3: r = macc[s];
                default: begin r = macc[s]; macc[s] = a; end
            endcase
        end
        exp_d.push_back(r);
        exp_s.push_back(st);
    endtask

    logic          prev_hold = 1'b0;
    logic          prev_v = 1'b0;
    logic [DW-1:0] prev_d;
    logic [1:0]    prev_s;
    logic [DW-1:0] ed;
    logic [1:0]    es;

    // Monitor: sample mid-cycle, track handshakes that complete at the next edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_d.delete();
            exp_s.delete();
            for (int i = 0; i < NS; i++) macc[i] = '0;
            chk("rst_resp_valid", bus.resp_valid, 0);
            chk("rst_req_ready", bus.req_ready, 0);
            chk("rst_resp_status", bus.resp_status, CFU_OK);
            chk("rst_resp_data", bus.resp_data, 0);
            prev_hold = 1'b0;
            prev_v    = 1'b0;
        end else begin
            chk("req_ready", bus.req_ready, exp_d.size() < FS);
            if (bus.resp_valid && exp_d.size() == 0) chk("spurious_valid", 1, 0);
            if (prev_hold) begin
                chk("hold_valid", bus.resp_valid, 1);
                chk("hold_data", bus.resp_data, prev_d);
                chk("hold_status", bus.resp_status, prev_s);
            end
            if (bus.resp_valid && !prev_v && first_resp_cyc < 0) first_resp_cyc = cyc;
            if (clk_en && bus.resp_valid && bus.resp_ready && exp_d.size() > 0) begin
                ed = exp_d.pop_front();
                es = exp_s.pop_front();
                chk("resp_status", bus.resp_status, es);
                chk("resp_data", bus.resp_data, ed);
                obs_d.push_back(bus.resp_data);
                obs_s.push_back(bus.resp_status);
            end
            if (clk_en && bus.req_valid && bus.req_ready) begin
                model_req(int'(bus.req_state), int'(bus.req_func), bus.req_data0, bus.req_data1);
                last_acc_edge = cyc + 1;
            end
            prev_hold = bus.resp_valid && !(clk_en && bus.resp_ready);
            prev_v    = bus.resp_valid;
            prev_d    = bus.resp_data;
            prev_s    = bus.resp_status;
        end
    end

    typedef struct {
        int            s;
        int            f;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] d;
        logic [1:0]    st;
    } vec_t;

    vec_t vt[$];

    task automatic addv(input int s, input int f, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [DW-1:0] d, input logic [1:0] st);
        vec_t v;
        v = '{s: s, f: f, a: a, b: b, d: d, st: st};
        vt.push_back(v);
    endtask

    task automatic send(input int s, input int f, input logic [DW-1:0] a, input logic [DW-1:0] b);
        bus.req_state = s[SW-1:0];
        bus.req_func  = f[FW-1:0];
        bus.req_data0 = a;
        bus.req_data1 = b;
        bus.req_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.req_ready && clk_en) begin
                @(posedge clk);
                #1;
                bus.req_valid = 1'b0;
                return;
            end
            stalls++;
            @(posedge clk);
            #1;
        end
        chk("send_timeout", 0, 1);
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 60; k++) begin
            if (exp_d.size() == 0) break;
            @(posedge clk);
            #1;
        end
        chk("drain_timeout", exp_d.size(), 0);
    endtask

    task automatic run_group(input int lo, input int hi);
        obs_d.delete();
        obs_s.delete();
        first_resp_cyc = -1;
        stalls = 0;
        for (int i = lo; i <= hi; i++) begin
            send(vt[i].s, vt[i].f, vt[i].a, vt[i].b);
            if (i == lo) grp_acc0 = last_acc_edge;
        end
        drain();
        chk($sformatf("grp%0d_count", lo), obs_d.size(), hi - lo + 1);
        for (int i = lo; i <= hi; i++) begin
            if (i - lo < obs_d.size()) begin
                chk($sformatf("vec%0d_data", i), obs_d[i-lo], vt[i].d);
                chk($sformatf("vec%0d_status", i), obs_s[i-lo], vt[i].st);
            end
        end
    endtask

    int acc_cnt;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Directed vectors with hand-computed results.
        addv(0, 0, 3, 5, 15, CFU_OK);                 // 0  MAC s0
        addv(0, 3, 0, 0, 15, CFU_OK);                 // 1  READ s0
        addv(1, 0, 7, 6, 42, CFU_OK);                 // 2  MAC s1
        addv(1, 0, 32'hFFFF_FFFF, 2, 40, CFU_OK);     // 3  wraps
        addv(1, 1, 4, 4, 24, CFU_OK);                 // 4  MSUB
        addv(0, 0, 2, 2, 19, CFU_OK);                 // 5
        addv(1, 0, 3, 3, 33, CFU_OK);                 // 6
        addv(2, 0, 10, 10, 100, CFU_OK);              // 7
        addv(0, 0, 1, 1, 20, CFU_OK);                 // 8
        addv(0, 3, 0, 0, 20, CFU_OK);                 // 9
        addv(1, 3, 0, 0, 33, CFU_OK);                 // 10
        addv(2, 3, 0, 0, 100, CFU_OK);                // 11
        addv(2, 0, 5, 5, 125, CFU_OK);                // 12
        addv(2, 4, 100, 9, 125, CFU_OK);              // 13 WRITE returns old
        addv(2, 3, 0, 0, 100, CFU_OK);                // 14
        addv(1, 2, 6, 7, 42, CFU_OK);                 // 15 MUL, acc untouched
        addv(1, 3, 0, 0, 33, CFU_OK);                 // 16
        addv(0, 7, 1, 1, 0, CFU_ERROR_OP);            // 17 bad func
        addv(3, 0, 9, 9, 0, CFU_ERROR_OP);            // 18 bad state
        addv(0, 3, 0, 0, 20, CFU_OK);                 // 19
        addv(0, 0, 1, 1, 21, CFU_OK);                 // 20
        addv(0, 3, 0, 0, 0, CFU_OK);                  // 21 post-reset reads
        addv(1, 3, 0, 0, 0, CFU_OK);                  // 22
        addv(2, 3, 0, 0, 0, CFU_OK);                  // 23

        bus.req_valid  = 1'b0;
        bus.req_state  = '0;
        bus.req_func   = '0;
        bus.req_data0  = '0;
        bus.req_data1  = '0;
        bus.resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_release", bus.req_ready, 1);
        @(posedge clk);
        #1;

        // Single MAC then READ, with latency measured from accept edge.
        run_group(0, 1);
        chk("latency", 64'(first_resp_cyc - grp_acc0), LAT);

        // Back-to-back on one state, no stalls allowed.
        run_group(2, 4);
        chk("b2b_stalls", stalls, 0);

        // Interleaved states, MUL, WRITE.
        run_group(5, 16);

        // Error requests keep order and leave accumulators alone.
        run_group(17, 20);

        // Backpressure: exactly FS accepts before req_ready drops.
        obs_d.delete();
        obs_s.delete();
        bus.resp_ready = 1'b0;
        acc_cnt = 0;
        bus.req_state = 2'd1;
        bus.req_func  = '0;
        bus.req_data0 = 1;
        bus.req_data1 = 1;
        bus.req_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.req_ready) acc_cnt++;
            @(posedge clk);
            #1;
        end
        chk("bp_accepts", acc_cnt, FS);
        chk("bp_ready_low", bus.req_ready, 0);
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        drain();
        chk("bp_count", obs_d.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < obs_d.size()) chk($sformatf("bp_data%0d", i), obs_d[i], 34 + i);
        end

        // Clock-enable freeze with a response waiting.
        obs_d.delete();
        obs_s.delete();
        bus.resp_ready = 1'b0;
        send(1, 3, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        clk_en = 1'b0;
        bus.resp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("freeze_valid", bus.resp_valid, 1);
            chk("freeze_data", bus.resp_data, 37);
        end
        @(posedge clk);
        #1;
        clk_en = 1'b1;
        drain();
        chk("freeze_count", obs_d.size(), 1);
        if (obs_d.size() > 0) chk("freeze_pop", obs_d[0], 37);

        // Reset with two in flight and two queued.
        bus.resp_ready = 1'b0;
        send(0, 0, 2, 3);
        send(1, 0, 2, 3);
        send(2, 0, 2, 3);
        send(0, 0, 2, 3);
        rst_n = 1'b0;
        #1;
        chk("reset_drops_valid", bus.resp_valid, 0);
        chk("reset_drops_ready", bus.req_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        chk("ready_after_midreset", bus.req_ready, 1);
        @(posedge clk);
        #1;
        run_group(21, 23);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
